// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: 640x480@60 raster scan generator and DAC output stage.
// It drives draw_x/draw_y to a combinational renderer. The renderer's
// colour/plot result is registered one pixel later, together with sync and blank.
// Optional feature: define VGA_TEST_PATTERN_EN to build the colour-bar
// generator that test_mode selects. Without it, test_mode is ignored.
module vga_scan_ctrl #(
    parameter int          CLK_DIV  = 2,
    parameter int          H_VIS    = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_VIS    = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter logic [23:0] BACK_RGB = 24'h000000
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    output logic [9:0]  draw_x,
    output logic [8:0]  draw_y,
    input  logic [23:0] VGA_COLOR,
    input  logic        plot,
    input  logic        test_mode,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        VGA_CLK,
    output logic        frame_start
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    localparam logic [9:0] H_VIS_L = 10'(H_VIS);
    localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_VIS_L = 10'(V_VIS);
    localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             blank_n_q, blank_n_d;
    logic [23:0]      rgb_q, rgb_d;

    logic             pix_en;
    logic             visible;
    logic             hs_raw;
    logic             vs_raw;
    logic [23:0]      pix_rgb;

    // Pixel strobe and the scan-position decodes shared by the renderer and output stage.
    always_comb begin
        pix_en  = (div_cnt_q == DIV_LAST);
        visible = (h_cnt_q < H_VIS_L) && (v_cnt_q < V_VIS_L);
        hs_raw  = ~((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
        vs_raw  = ~((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
        // Outside the visible window the renderer sees (0,0), so blanking lines never alias.
        draw_x  = visible ? h_cnt_q : 10'd0;
        draw_y  = visible ? v_cnt_q[8:0] : 9'd0;
        VGA_CLK = (div_cnt_q < DIV_HALF);
        frame_start = pix_en && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
        VGA_SYNC_N  = 1'b1;
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] BAR_W = 10'(H_VIS / 8);

    logic [2:0]  bar_idx;
    logic [23:0] bar_rgb;

    // Eight vertical bars: white, yellow, cyan, green, magenta, red, blue, black.
    always_comb begin
        bar_idx = 3'(h_cnt_q / BAR_W);
        bar_rgb = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
    end

    // Colour source for a visible pixel: bars override the renderer in test mode.
    always_comb begin
        pix_rgb = plot ? VGA_COLOR : BACK_RGB;
        if (test_mode) begin
            pix_rgb = bar_rgb;
        end
    end
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;

    // Colour source for a visible pixel: renderer colour or the background.
    always_comb begin
        pix_rgb = plot ? VGA_COLOR : BACK_RGB;
    end
`endif

    // Next state for the divider, the scan counters and the aligned output stage.
    always_comb begin
        div_cnt_d = pix_en ? '0 : div_cnt_q + 1'b1;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        rgb_d     = rgb_q;
        if (pix_en) begin
            h_cnt_d = (h_cnt_q == H_LAST) ? 10'd0 : h_cnt_q + 10'd1;
            if (h_cnt_q == H_LAST) begin
                v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end
            // Sync, blank and colour all describe the pixel that is ending now.
            hs_d      = hs_raw;
            vs_d      = vs_raw;
            blank_n_d = visible;
            rgb_d     = visible ? pix_rgb : 24'h000000;
        end
    end

    // State registers; reset abandons the frame and restarts at (0,0) with syncs idle.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            div_cnt_q <= '0;
            h_cnt_q   <= 10'd0;
            v_cnt_q   <= 10'd0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            rgb_q     <= 24'h000000;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            rgb_q     <= rgb_d;
        end
    end

    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_R       = rgb_q[23:16];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: directed checks of vga_scan_ctrl.
// dut uses full 640x480 timing with BACK_RGB=24'h102030. dut_s uses a shrunken
// 32x19 raster so whole frames, vsync and mid-frame reset fit in a short run.
module tb_vga_scan_ctrl;

`ifdef VGA_TEST_PATTERN_EN
    localparam bit TP = 1'b1;
`else
    localparam bit TP = 1'b0;
`endif

    // small raster geometry
    localparam int SH = 32;
    localparam int SV = 19;
    localparam int SF = SH * SV;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst_s_n, plot, test_mode;

    logic [9:0]  dx;
    logic [8:0]  dy;
    logic [23:0] color;
    logic [7:0]  vr, vg, vb;
    logic        hs, vs, blank_n, sync_n, vclk, fs;

    logic [9:0]  dx_s;
    logic [8:0]  dy_s;
    logic [23:0] color_s;
    logic [7:0]  vr_s, vg_s, vb_s;
    logic        hs_s, vs_s, blank_n_s, sync_n_s, vclk_s, fs_s;

    // Renderer stubs: colour = {x, y, 5A}.
    assign color   = {dx[7:0], dy[7:0], 8'h5A};
    assign color_s = {dx_s[7:0], dy_s[7:0], 8'h5A};

    vga_scan_ctrl #(.BACK_RGB(24'h102030)) dut (
        .CLOCK_50(clk), .resetn(rst_n), .draw_x(dx), .draw_y(dy),
        .VGA_COLOR(color), .plot(plot), .test_mode(test_mode),
        .VGA_R(vr), .VGA_G(vg), .VGA_B(vb), .VGA_HS(hs), .VGA_VS(vs),
        .VGA_BLANK_N(blank_n), .VGA_SYNC_N(sync_n), .VGA_CLK(vclk),
        .frame_start(fs)
    );

    vga_scan_ctrl #(
        .H_VIS(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_VIS(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_s (
        .CLOCK_50(clk), .resetn(rst_s_n), .draw_x(dx_s), .draw_y(dy_s),
        .VGA_COLOR(color_s), .plot(plot), .test_mode(test_mode),
        .VGA_R(vr_s), .VGA_G(vg_s), .VGA_B(vb_s), .VGA_HS(hs_s), .VGA_VS(vs_s),
        .VGA_BLANK_N(blank_n_s), .VGA_SYNC_N(sync_n_s), .VGA_CLK(vclk_s),
        .frame_start(fs_s)
    );

    int total = 0;
    int bad   = 0;
    int cyc_m = 0;
    int cyc_s = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, want);
        end
    endtask

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc_m++;
            cyc_s++;
        end
        #1;
    endtask

    // advance the main DUT until its outputs show pixel (x,y) of the first frame
    task automatic show_m(input int x, input int y);
        int t;
        t = 2 * (y * 800 + x + 1);
        if (t > cyc_m) step(t - cyc_m);
    endtask

    initial begin
        int hs_err, vs_err, bl_err, rgb_err, dr_err;
        int fs_cnt, fs_first, fs_second, first_low;
        int k, shown, sx, sy, p, cx, cy;
        logic ev;

        rst_n = 1'b0; rst_s_n = 1'b0; plot = 1'b1; test_mode = 1'b0;
        step(10);
        chk("rst_hs", hs, 1'b1);
        chk("rst_vs", vs, 1'b1);
        chk("rst_blank", blank_n, 1'b0);
        chk("rst_rgb", {vr, vg, vb}, 24'h0);
        chk("rst_dx", dx, 10'd0);
        chk("rst_dy", dy, 9'd0);
        chk("rst_sync_n", sync_n, 1'b1);
        chk("rst_fs", fs, 1'b0);
        chk("rst_vclk", vclk, 1'b1);
        chk("rst_s_vs", vs_s, 1'b1);

        // release: first pix_en lands on the 2nd edge
        rst_n = 1'b1; cyc_m = 0;
        step(1);
        chk("e1_dx", dx, 10'd0);
        chk("e1_blank", blank_n, 1'b0);
        chk("e1_vclk", vclk, 1'b0);
        step(1);
        chk("e2_dx", dx, 10'd1);
        chk("e2_blank", blank_n, 1'b1);
        chk("e2_vclk", vclk, 1'b1);
        chk("p0_0_rgb", {vr, vg, vb}, 24'h00005A);
        chk("p0_0_hs", hs, 1'b1);

        show_m(639, 0);
        chk("p639_rgb", {vr, vg, vb}, 24'h7F005A);
        chk("p639_blank", blank_n, 1'b1);
        show_m(640, 0);
        chk("p640_blank", blank_n, 1'b0);
        chk("p640_rgb", {vr, vg, vb}, 24'h0);
        chk("p640_dx", dx, 10'd0);
        chk("p640_dy", dy, 9'd0);
        show_m(655, 0);
        chk("hs_655", hs, 1'b1);
        show_m(656, 0);
        chk("hs_656", hs, 1'b0);
        step(1);
        chk("hs_656_mid", hs, 1'b0);
        chk("dx_657_mid", dx, 10'd0);
        show_m(751, 0);
        chk("hs_751", hs, 1'b0);
        show_m(752, 0);
        chk("hs_752", hs, 1'b1);
        show_m(799, 0);
        chk("wrap_dx", dx, 10'd0);
        chk("wrap_dy", dy, 9'd1);
        chk("wrap_blank", blank_n, 1'b0);
        show_m(0, 1);
        chk("p0_1_rgb", {vr, vg, vb}, 24'h00015A);

        plot = 1'b0;
        show_m(50, 5);
        chk("back_rgb", {vr, vg, vb}, 24'h102030);
        chk("back_blank", blank_n, 1'b1);
        show_m(700, 10);
        chk("p700_10_rgb", {vr, vg, vb}, 24'h0);
        chk("p700_10_blank", blank_n, 1'b0);
        chk("p700_10_vs", vs, 1'b1);

        plot = 1'b1;
        show_m(99, 37);
        chk("p99_37_rgb", {vr, vg, vb}, 24'h63255A);
        chk("p99_37_dx", dx, 10'd100);
        chk("p99_37_dy", dy, 9'd37);
        show_m(100, 37);
        chk("p100_37_rgb", {vr, vg, vb}, 24'h64255A);
        chk("p100_37_blank", blank_n, 1'b1);

        // asynchronous reset mid-pixel: outputs drop without a clock edge
        step(1);
        rst_n = 1'b0;
        #1;
        chk("arst_hs", hs, 1'b1);
        chk("arst_vs", vs, 1'b1);
        chk("arst_blank", blank_n, 1'b0);
        chk("arst_rgb", {vr, vg, vb}, 24'h0);
        chk("arst_dx", dx, 10'd0);
        chk("arst_dy", dy, 9'd0);
        step(3);

        test_mode = 1'b1;
        rst_n = 1'b1; cyc_m = 0;
        show_m(0, 0);
        chk("rs_p0_dx", dx, 10'd1);
        chk("rs_p0_dy", dy, 9'd0);
        chk("rs_p0_vs", vs, 1'b1);
        chk("rs_p0_blank", blank_n, 1'b1);
        chk("tm_x0", {vr, vg, vb}, TP ? 24'hFFFFFF : 24'h00005A);
        show_m(85, 0);
        chk("tm_x85", {vr, vg, vb}, TP ? 24'hFFFF00 : 24'h55005A);
        show_m(639, 0);
        chk("tm_x639", {vr, vg, vb}, TP ? 24'h000000 : 24'h7F005A);
        chk("tm_x639_blank", blank_n, 1'b1);
        show_m(0, 1);
        chk("tm_x0_y1", {vr, vg, vb}, TP ? 24'hFFFFFF : 24'h00015A);
        test_mode = 1'b0;
        show_m(1, 1);
        chk("tm_off_x1_y1", {vr, vg, vb}, 24'h01015A);

        // small raster: two whole frames against a position model
        hs_err = 0; vs_err = 0; bl_err = 0; rgb_err = 0; dr_err = 0;
        fs_cnt = 0; fs_first = -1; fs_second = -1;
        rst_s_n = 1'b1; cyc_s = 0;
        for (int e = 1; e <= 2500; e++) begin
            step(1);
            if (fs_s) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = e;
                else if (fs_second < 0) fs_second = e;
            end
            k  = e / 2;
            p  = k % SF;
            cx = p % SH;
            cy = p / SH;
            ev = (cx < 16) && (cy < 12);
            if (dx_s !== (ev ? 10'(cx) : 10'd0)) dr_err++;
            if (dy_s !== (ev ? 9'(cy) : 9'd0)) dr_err++;
            if (k >= 1) begin
                shown = (k - 1) % SF;
                sx = shown % SH;
                sy = shown / SH;
                ev = (sx < 16) && (sy < 12);
                if (hs_s !== !((sx >= 20) && (sx <= 25))) hs_err++;
                if (vs_s !== !((sy >= 14) && (sy <= 15))) vs_err++;
                if (blank_n_s !== ev) bl_err++;
                if ({vr_s, vg_s, vb_s} !== (ev ? {8'(sx), 8'(sy), 8'h5A} : 24'h0)) rgb_err++;
            end
        end
        chk("s_hs_errs", hs_err, 0);
        chk("s_vs_errs", vs_err, 0);
        chk("s_blank_errs", bl_err, 0);
        chk("s_rgb_errs", rgb_err, 0);
        chk("s_draw_errs", dr_err, 0);
        chk("s_fs_count", fs_cnt, 2);
        chk("s_fs_first", fs_first, 1215);
        chk("s_fs_second", fs_second, 2431);

        // reset in the middle of a vsync pulse; new frame must give a full pulse later
        step(3340 - cyc_s);
        chk("s_vs_before_rst", vs_s, 1'b0);
        step(1);
        rst_s_n = 1'b0;
        #1;
        chk("s_arst_vs", vs_s, 1'b1);
        chk("s_arst_hs", hs_s, 1'b1);
        chk("s_arst_blank", blank_n_s, 1'b0);
        chk("s_arst_rgb", {vr_s, vg_s, vb_s}, 24'h0);
        step(3);
        rst_s_n = 1'b1; cyc_s = 0;
        first_low = -1;
        for (int e = 1; e <= 1000; e++) begin
            step(1);
            if (!vs_s && first_low < 0) first_low = e;
        end
        chk("s_vs_first_low", first_low, 898);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
